// File: rtl/lc3_datapath_mem_if.sv
// Memory-side handshake bundle for lc3_datapath_mem: request/ack with address and data.
// The datapath is the master, the memory/IO subsystem is the slave.
interface lc3_datapath_mem_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lc3_datapath_mem.sv
// LC-3 style datapath with a handshaked memory sequencer and sticky bus/memory error flags.
// The control FSM drives loads, gates and mux selects; memory is reached through the _if bundle.
module lc3_datapath_mem #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREG     = 8,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               LD_MAR,
  input  logic               LD_MDR,
  input  logic               LD_IR,
  input  logic               LD_BEN,
  input  logic               LD_CC,
  input  logic               LD_REG,
  input  logic               LD_PC,
  input  logic               GatePC,
  input  logic               GateMDR,
  input  logic               GateALU,
  input  logic               GateMARMUX,
  input  logic [1:0]         PCMUX,
  input  logic [1:0]         ADDR2MUX,
  input  logic               ADDR1MUX,
  input  logic [1:0]         ALUK,
  input  logic               SR1MUX,
  input  logic               DRMUX,
  input  logic               SR2MUX,
  input  logic               MEM_START,
  input  logic               MEM_WE,
  output logic               MEM_DONE,
  output logic               MEM_BUSY,
  lc3_datapath_mem_if.master mem,
  output logic [WIDTH-1:0]   PC,
  output logic [WIDTH-1:0]   IR,
  output logic [WIDTH-1:0]   MAR,
  output logic [WIDTH-1:0]   MDR,
  output logic               BEN,
  output logic               BUS_ERR,
  output logic               MEM_ERR
);
  localparam int unsigned RSEL = $clog2(NREG);
  localparam int unsigned CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} mem_st_e;

  mem_st_e          st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             mdr_from_mem, timeout, busy;

  logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [2:0]       cc_q;
  logic             ben_q, bus_err_q, mem_err_q;

  logic [RSEL-1:0]  sr1, sr2, dr;
  logic [WIDTH-1:0] sr1_out, sr2_op, alu_out, addr1, addr2, addr_sum, pc_mux, bus;
  logic [WIDTH-1:0] sext5, sext6, sext9, sext11;
  logic [3:0]       gates;
  logic             multi_gate;

  assign sr1 = SR1MUX ? ir_q[9 +: RSEL] : ir_q[6 +: RSEL];
  assign sr2 = ir_q[0 +: RSEL];
  assign dr  = DRMUX ? RSEL'(NREG - 1) : ir_q[9 +: RSEL];

  assign sr1_out = rf_q[sr1];
  assign sext5   = WIDTH'($signed(ir_q[4:0]));
  assign sext6   = WIDTH'($signed(ir_q[5:0]));
  assign sext9   = WIDTH'($signed(ir_q[8:0]));
  assign sext11  = WIDTH'($signed(ir_q[10:0]));
  assign sr2_op  = SR2MUX ? sext5 : rf_q[sr2];

  always_comb begin
    alu_out = '0;
    unique case (ALUK)
      2'd0:    alu_out = sr1_out + sr2_op;
      2'd1:    alu_out = sr1_out & sr2_op;
      2'd2:    alu_out = ~sr1_out;
      default: alu_out = sr1_out;
    endcase
  end

  always_comb begin
    addr2 = '0;
    unique case (ADDR2MUX)
      2'd0:    addr2 = '0;
      2'd1:    addr2 = sext6;
      2'd2:    addr2 = sext9;
      default: addr2 = sext11;
    endcase
  end

  assign addr1    = ADDR1MUX ? pc_q : sr1_out;
  assign addr_sum = addr1 + addr2;

  // Contention is resolved to a quiet bus rather than an OR of drivers.
  assign gates      = {GatePC, GateMDR, GateALU, GateMARMUX};
  assign multi_gate = (gates & (gates - 4'd1)) != 4'd0;

  always_comb begin
    bus = '0;
    if (!multi_gate) begin
      if (GatePC)     bus = pc_q;
      if (GateMDR)    bus = mdr_q;
      if (GateALU)    bus = alu_out;
      if (GateMARMUX) bus = addr_sum;
    end
  end

  always_comb begin
    pc_mux = pc_q;
    unique case (PCMUX)
      2'd0:    pc_mux = pc_q + WIDTH'(1);
      2'd1:    pc_mux = addr_sum;
      2'd2:    pc_mux = bus;
      default: pc_mux = pc_q;
    endcase
  end

  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    mdr_from_mem = 1'b0;
    timeout      = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (MEM_START) begin
          st_d  = StReq;
          we_d  = MEM_WE;
          cnt_d = '0;
        end
      end
      StReq: begin
        if (mem.mem_ack) begin
          st_d         = StDone;
          mdr_from_mem = !we_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          st_d    = StDone;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q  <= StIdle;
      cnt_q <= '0;
      we_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      we_q  <= we_d;
    end
  end

  assign busy = (st_q != StIdle);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= WIDTH'(RESET_PC);
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      cc_q      <= 3'b010;
      ben_q     <= 1'b0;
      bus_err_q <= 1'b0;
      mem_err_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (LD_PC) pc_q <= pc_mux;
      if (LD_IR) ir_q <= bus;
      // MAR/MDR must stay stable while an access is in flight.
      if (LD_MAR && !busy) mar_q <= bus;
      if (mdr_from_mem) mdr_q <= mem.mem_rdata;
      else if (LD_MDR && !busy) mdr_q <= bus;
      if (LD_CC) cc_q <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};
      if (LD_BEN) ben_q <= (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) | (ir_q[9] & cc_q[0]);
      if (LD_REG) rf_q[dr] <= bus;
      bus_err_q <= bus_err_q | multi_gate;
      mem_err_q <= mem_err_q | timeout;
    end
  end

  assign mem.mem_req   = (st_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;

  assign MEM_DONE = (st_q == StDone);
  assign MEM_BUSY = busy;
  assign PC       = pc_q;
  assign IR       = ir_q;
  assign MAR      = mar_q;
  assign MDR      = mdr_q;
  assign BEN      = ben_q;
  assign BUS_ERR  = bus_err_q;
  assign MEM_ERR  = mem_err_q;
endmodule

// File: tb/tb_lc3_datapath_mem.sv
// Scoreboard bench for lc3_datapath_mem: stimulus updates a behavioural model and queues
// expectations; a monitor compares snapshots and completed memory accesses.
module tb_lc3_datapath_mem;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NREG     = 8;
  localparam logic [15:0] RESET_PC = 16'h3000;
  localparam int unsigned TIMEOUT  = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        ADDR1MUX, SR1MUX, DRMUX, SR2MUX, MEM_START, MEM_WE;
  logic        MEM_DONE, MEM_BUSY, BEN, BUS_ERR, MEM_ERR;
  logic [15:0] PC, IR, MAR, MDR;

  lc3_datapath_mem_if #(.WIDTH(WIDTH)) mem ();

  lc3_datapath_mem #(
    .WIDTH(WIDTH), .NREG(NREG), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .ALUK(ALUK),
    .SR1MUX(SR1MUX), .DRMUX(DRMUX), .SR2MUX(SR2MUX),
    .MEM_START(MEM_START), .MEM_WE(MEM_WE), .MEM_DONE(MEM_DONE), .MEM_BUSY(MEM_BUSY),
    .mem(mem),
    .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR),
    .BEN(BEN), .BUS_ERR(BUS_ERR), .MEM_ERR(MEM_ERR)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] pc, ir, mar, mdr;
    logic        ben, bus_err, mem_err, busy, req;
  } snap_t;

  typedef struct packed {
    logic [15:0] mdr, addr;
    logic        we, err;
    int unsigned reqs;
  } acc_t;

  snap_t snap_q[$];
  acc_t  acc_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Reference model state; cc holds the sign of the last CC-loaded value (-1/0/+1).
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [15:0] m_reg [NREG];
  int          m_cc;
  logic        m_ben, m_bus_err, m_mem_err;
  // 256-word memory image aliased on the low address byte.
  logic [15:0] ref_mem [256];
  logic [15:0] sim_mem [256];
  int          ack_lat;

  function automatic void chk16(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = v & 16'((1 << bits) - 1);
    if (v[bits-1]) r = r - 16'(1 << bits);
    return r;
  endfunction

  function automatic int sign_of(input logic [15:0] v);
    if ($signed(v) < 0) return -1;
    if (v == 16'h0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_ir = '0; m_mar = '0; m_mdr = '0;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_cc = 0; m_ben = 0; m_bus_err = 0; m_mem_err = 0;
  endtask

  task automatic idle_ctrl();
    LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_CC = 0; LD_REG = 0; LD_PC = 0;
    GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
    PCMUX = 0; ADDR2MUX = 0; ADDR1MUX = 0; ALUK = 0;
    SR1MUX = 0; DRMUX = 0; SR2MUX = 0; MEM_START = 0; MEM_WE = 0;
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic push_snap();
    snap_t s;
    s.pc = m_pc; s.ir = m_ir; s.mar = m_mar; s.mdr = m_mdr; s.ben = m_ben;
    s.bus_err = m_bus_err; s.mem_err = m_mem_err; s.busy = 0; s.req = 0;
    snap_q.push_back(s);
  endtask

  // lat in 1..TIMEOUT acks in that REQ cycle; anything else never acks.
  task automatic mem_access(input logic we, input int lat, input bit disturb);
    acc_t a;
    int   n;
    ack_lat = lat;
    MEM_START = 1; MEM_WE = we;
    a.addr = m_mar; a.we = we;
    if (lat >= 1 && lat <= int'(TIMEOUT)) begin
      a.reqs = lat;
      if (we) ref_mem[m_mar[7:0]] = m_mdr;
      else m_mdr = ref_mem[m_mar[7:0]];
    end else begin
      a.reqs = TIMEOUT;
      m_mem_err = 1;
    end
    a.mdr = m_mdr; a.err = m_mem_err;
    acc_q.push_back(a);
    tick();
    MEM_START = 0; MEM_WE = 0;
    if (disturb) begin
      LD_MDR = 1; LD_MAR = 1; GatePC = 1; MEM_START = 1; MEM_WE = ~we;
      tick();
      idle_ctrl();
    end
    n = 0;
    while (MEM_BUSY && n < 20) begin
      tick();
      n++;
    end
    if (MEM_BUSY) begin
      n_vec++; n_bad++;
      $display("FAIL access_complete: got busy after 20 cycles expected idle");
    end
    push_snap();
  endtask

  task automatic set_mdr(input logic [15:0] v);
    ref_mem[m_mar[7:0]] = v;
    sim_mem[m_mar[7:0]] = v;
    mem_access(1'b0, $urandom_range(1, TIMEOUT), 1'b0);
  endtask

  task automatic load_ir(input logic [15:0] v);
    set_mdr(v);
    GateMDR = 1; LD_IR = 1; tick(); idle_ctrl();
    m_ir = v;
  endtask

  task automatic set_mar(input logic [15:0] v);
    set_mdr(v);
    GateMDR = 1; LD_MAR = 1; tick(); idle_ctrl();
    m_mar = v;
    push_snap();
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
    load_ir({4'h0, r, 9'h0});
    set_mdr(v);
    GateMDR = 1; LD_REG = 1; DRMUX = 0; tick(); idle_ctrl();
    m_reg[r] = v;
  endtask

  task automatic probe_reg(input logic [2:0] r);
    load_ir({7'h0, r, 6'h0});
    SR1MUX = 0; ALUK = 2'd3; GateALU = 1; LD_PC = 1; PCMUX = 2'd2; tick(); idle_ctrl();
    m_pc = m_reg[r];
    push_snap();
  endtask

  task automatic alu_op(input logic [15:0] ir, input logic [1:0] k, input logic s2,
                        input logic s1, input logic d, input logic cc);
    logic [15:0] a, b, r;
    int          dst;
    load_ir(ir);
    a = m_reg[s1 ? ir[11:9] : ir[8:6]];
    b = s2 ? sext(ir, 5) : m_reg[ir[2:0]];
    case (k)
      2'd0:    r = a + b;
      2'd1:    r = a & b;
      2'd2:    r = ~a;
      default: r = a;
    endcase
    dst = d ? NREG - 1 : int'(ir[11:9]);
    ALUK = k; SR2MUX = s2; SR1MUX = s1; DRMUX = d; GateALU = 1; LD_REG = 1; LD_CC = cc;
    tick(); idle_ctrl();
    m_reg[dst] = r;
    if (cc) m_cc = sign_of(r);
    push_snap();
  endtask

  task automatic addr_op(input logic [15:0] ir, input logic a1, input logic [1:0] a2,
                         input logic s1);
    logic [15:0] base, off;
    load_ir(ir);
    base = a1 ? m_pc : m_reg[s1 ? ir[11:9] : ir[8:6]];
    case (a2)
      2'd0:    off = 16'h0;
      2'd1:    off = sext(ir, 6);
      2'd2:    off = sext(ir, 9);
      default: off = sext(ir, 11);
    endcase
    ADDR1MUX = a1; ADDR2MUX = a2; SR1MUX = s1;
    GateMARMUX = 1; LD_MAR = 1; LD_PC = 1; PCMUX = 2'd1; tick(); idle_ctrl();
    m_mar = base + off; m_pc = base + off;
    push_snap();
  endtask

  task automatic ben_op();
    LD_BEN = 1; tick(); idle_ctrl();
    m_ben = (m_ir[11] && m_cc < 0) || (m_ir[10] && m_cc == 0) || (m_ir[9] && m_cc > 0);
    push_snap();
  endtask

  // Memory responder: acks in the programmed REQ cycle; throws stray acks while idle.
  initial begin : responder
    int rcnt;
    rcnt = 0;
    mem.mem_ack = 0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge Clk);
      mem.mem_ack = 0;
      if (mem.mem_req) begin
        rcnt++;
        if (rcnt == ack_lat) begin
          mem.mem_ack = 1;
          if (mem.mem_we) sim_mem[mem.mem_addr[7:0]] = mem.mem_wdata;
          else mem.mem_rdata = sim_mem[mem.mem_addr[7:0]];
        end
      end else begin
        rcnt = 0;
        if ($urandom_range(0, 7) == 0) begin
          mem.mem_ack = 1;
          mem.mem_rdata = 16'($urandom);
        end
      end
    end
  end

  initial begin : monitor
    int          req_cnt;
    logic [15:0] req_addr;
    logic        req_we, addr_moved;
    snap_t       s;
    acc_t        a;
    req_cnt = 0; req_addr = '0; req_we = 0; addr_moved = 0;
    forever begin
      @(negedge Clk);
      #1;
      if (!Reset_n) begin
        req_cnt = 0;
        addr_moved = 0;
      end
      if (mem.mem_req) begin
        if (req_cnt == 0) begin
          req_addr = mem.mem_addr;
          req_we = mem.mem_we;
        end else if (mem.mem_addr !== req_addr) begin
          addr_moved = 1;
        end
        req_cnt++;
      end
      if (MEM_DONE) begin
        if (acc_q.size() == 0) begin
          chk1("unexpected_mem_done", MEM_DONE, 1'b0);
        end else begin
          a = acc_q.pop_front();
          chk16("acc_mdr", MDR, a.mdr);
          chk1("acc_mem_err", MEM_ERR, a.err);
          chk16("acc_req_cycles", 16'(req_cnt), 16'(a.reqs));
          chk16("acc_addr", req_addr, a.addr);
          chk1("acc_we", req_we, a.we);
          chk1("acc_addr_stable", addr_moved, 1'b0);
        end
        req_cnt = 0;
        addr_moved = 0;
      end
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk16("pc", PC, s.pc);
        chk16("ir", IR, s.ir);
        chk16("mar", MAR, s.mar);
        chk16("mdr", MDR, s.mdr);
        chk1("ben", BEN, s.ben);
        chk1("bus_err", BUS_ERR, s.bus_err);
        chk1("mem_err", MEM_ERR, s.mem_err);
        chk1("mem_busy", MEM_BUSY, s.busy);
        chk1("mem_req", mem.mem_req, s.req);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'($urandom);
      sim_mem[i] = ref_mem[i];
    end
    idle_ctrl();
    ack_lat = 0;
    Reset_n = 1;
    #2 Reset_n = 0;
    model_reset();
    tick();
    tick();
    Reset_n = 1;
    push_snap();

    repeat (3) begin
      LD_PC = 1; PCMUX = 2'd0; tick(); idle_ctrl();
      m_pc = m_pc + 16'd1;
    end
    push_snap();

    // BRz right after reset: CC is Z.
    load_ir(16'h0400);
    ben_op();

    load_reg(3'd1, 16'd5);
    alu_op(16'h1262, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    probe_reg(3'd1);
    load_ir(16'h0400);
    ben_op();

    set_mar(16'h0030);
    ref_mem[8'h30] = 16'hBEEF;
    sim_mem[8'h30] = 16'hBEEF;
    mem_access(1'b0, 3, 1'b1);

    set_mar(16'h0040);
    set_mdr(16'h1234);
    mem_access(1'b1, 0, 1'b0);

    GatePC = 1; GateALU = 1; LD_PC = 1; PCMUX = 2'd2; tick(); idle_ctrl();
    m_pc = 16'h0; m_bus_err = 1;
    push_snap();

    // Abort an access with reset while it is in REQ.
    ack_lat = 0;
    MEM_START = 1; tick(); MEM_START = 0; tick();
    Reset_n = 0;
    model_reset();
    push_snap();
    tick();
    Reset_n = 1;
    set_mdr(16'hA5A5);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: load_reg(3'($urandom), 16'($urandom));
        1: begin
          alu_op(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
          probe_reg(3'($urandom));
        end
        2: addr_op(16'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        3: mem_access(1'($urandom), $urandom_range(0, TIMEOUT), 1'($urandom));
        default: begin
          load_ir(16'($urandom));
          ben_op();
        end
      endcase
    end

    tick();
    tick();
    chk16("acc_queue_drained", 16'(acc_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
